// File: rtl/byte_readout_pkg.sv
// Shared types and helpers for the byte readout sequencer.
// Optional checksum byte is enabled by defining READOUT_CSUM_EN.
package byte_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CSUM,
    WAIT_CS,
    DONE
  } state_e;

  localparam logic [7:0] DST_IDLE = 8'hFF;

  function automatic int nbytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/byte_readout_ctrl_if.sv
// Host/counter-bank bus of the byte readout sequencer.
// The master side is the host plus counter bank; the slave side is the sequencer.
interface byte_readout_ctrl_if #(
  parameter int BITS     = 32,
  parameter int CHANNELS = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                     start;
  logic [CH_W-1:0]          ch_sel;
  logic [CHANNELS*BITS-1:0] src;
  logic                     rd_strobe;
  logic [7:0]               dst;
  logic                     dst_valid;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, ch_sel, src, rd_strobe,
    input  dst, dst_valid, busy, done, err
  );

  modport slave (
    input  start, ch_sel, src, rd_strobe,
    output dst, dst_valid, busy, done, err
  );
endinterface

// File: rtl/byte_readout_ctrl_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detector for the host read strobe.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= strobe_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/byte_readout_ctrl.sv
// Snapshots one encoder counter on start and streams it LSB-first, one byte per host strobe.
// Define READOUT_CSUM_EN to append an XOR checksum byte to every frame.
module byte_readout_ctrl
  import byte_readout_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CHANNELS = 2,
  parameter int TIMEOUT  = 0
) (
  input logic               clk,
  input logic               rst,
  byte_readout_ctrl_if.slave bus
);

  localparam int NBYTES = nbytes(BITS);
  localparam int SNAP_W = NBYTES * 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);

  state_e              state_q, state_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [7:0]          dst_q, dst_d;
  logic                dst_valid_q, dst_valid_d;
  logic                err_q, err_d;
`ifdef READOUT_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                rd_rise;
  logic [BITS-1:0]     sel_word;
  logic [7:0]          cur_byte;
  logic                last_byte;
  logic                tmo_hit;

  strobe_sync u_strobe_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (bus.rd_strobe),
    .rise_o   (rd_rise)
  );

  // Out-of-range channel selects read back as an all-ones counter.
  always_comb begin
    sel_word = '1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(bus.ch_sel) == k) sel_word = bus.src[k*BITS +: BITS];
    end
  end

  assign cur_byte  = snap_q[8*idx_q +: 8];
  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));
  assign tmo_hit   = TMO_EN && (tmr_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      dst_q       <= DST_IDLE;
      dst_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef READOUT_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      dst_q       <= dst_d;
      dst_valid_q <= dst_valid_d;
      err_q       <= err_d;
`ifdef READOUT_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // NOTE: every next-state signal is defaulted to its current value first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    dst_d       = dst_q;
    dst_valid_d = dst_valid_q;
    err_d       = err_q;
`ifdef READOUT_CSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d  = SNAP_W'(sel_word);
          idx_d   = '0;
          err_d   = 1'b0;
`ifdef READOUT_CSUM_EN
          csum_d  = '0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        dst_d       = cur_byte;
        dst_valid_d = 1'b1;
        tmr_d       = '0;
`ifdef READOUT_CSUM_EN
        csum_d      = csum_q ^ cur_byte;
`endif
        state_d     = WAIT;
      end
      WAIT: begin
        if (rd_rise) begin
          dst_d       = DST_IDLE;
          dst_valid_d = 1'b0;
          if (last_byte) begin
`ifdef READOUT_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end else if (tmo_hit) begin
          dst_d       = DST_IDLE;
          dst_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`ifdef READOUT_CSUM_EN
      CSUM: begin
        dst_d       = csum_q;
        dst_valid_d = 1'b1;
        tmr_d       = '0;
        state_d     = WAIT_CS;
      end
      WAIT_CS: begin
        if (rd_rise) begin
          dst_d       = DST_IDLE;
          dst_valid_d = 1'b0;
          state_d     = DONE;
        end else if (tmo_hit) begin
          dst_d       = DST_IDLE;
          dst_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A second start mid-frame only flags the host; the frame carries on.
    if (bus.start && (state_q != IDLE)) err_d = 1'b1;
  end

  always_comb begin
    bus.dst       = dst_q;
    bus.dst_valid = dst_valid_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_byte_readout_ctrl.sv
// Randomized self-checking bench for byte_readout_ctrl against a frame-level byte model.
// Expected frame length follows READOUT_CSUM_EN the same way as the design.
module tb_byte_readout_ctrl;

  localparam int BITS     = 32;
  localparam int CHANNELS = 3;
  localparam int TIMEOUT  = 16;
  localparam int NB       = (BITS + 7) / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [7:0] exp_q[$];

  byte_readout_ctrl_if #(.BITS(BITS), .CHANNELS(CHANNELS)) bus ();

  byte_readout_ctrl #(
    .BITS     (BITS),
    .CHANNELS (CHANNELS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame model: counter word picked by channel (all ones if out of range), split LSB first.
  function automatic void model_frame(input logic [CHANNELS*BITS-1:0] s, input int ch);
    logic [BITS-1:0] w;
    logic [7:0]      b;
    logic [7:0]      cs;
    exp_q.delete();
    w  = (ch < CHANNELS) ? s[ch*BITS +: BITS] : '1;
    cs = 8'h00;
    for (int i = 0; i < NB; i++) begin
      b = 8'(w >> (8 * i));
      exp_q.push_back(b);
      cs ^= b;
    end
`ifdef READOUT_CSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  task automatic wait_valid(input logic want, input string tag);
    int n = 0;
    while (bus.dst_valid !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.dst_valid, want);
  endtask

  task automatic read_byte(input logic [7:0] exp, input string tag);
    wait_valid(1'b1, {tag, "_valid"});
    check({tag, "_data"}, bus.dst, exp);
    check({tag, "_busy"}, bus.busy, 1'b1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    bus.rd_strobe = 1'b1;
    wait_valid(1'b0, {tag, "_consumed"});
    check({tag, "_idle_ff"}, bus.dst, 8'hFF);
    bus.rd_strobe = 1'b0;
  endtask

  task automatic pulse_start(input int ch);
    bus.ch_sel = 2'(ch);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic run_frame(input int ch, input int dup_at, input string name);
    int d0;
    model_frame(bus.src, ch);
    d0 = done_cnt;
    pulse_start(ch);
    check({name, "_err_cleared"}, bus.err, 1'b0);
    check({name, "_busy_on"}, bus.busy, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == dup_at) begin
        pulse_start(ch);
        check({name, "_dup_err"}, bus.err, 1'b1);
      end
      read_byte(exp_q[i], $sformatf("%s_b%0d", name, i));
      bus.src = {$urandom, $urandom, $urandom};
    end
    check({name, "_done_hi"}, bus.done, 1'b1);
    @(negedge clk);
    check({name, "_done_lo"}, bus.done, 1'b0);
    check({name, "_busy_off"}, bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
    if (dup_at >= 0) check({name, "_err_sticky"}, bus.err, 1'b1);
  endtask

  initial begin
    int d0;
    int n;
    bus.start     = 1'b0;
    bus.ch_sel    = '0;
    bus.src       = '0;
    bus.rd_strobe = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_dst", bus.dst, 8'hFF);
    check("rst_valid", bus.dst_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    // Strobes while idle must not produce anything.
    for (int i = 0; i < 4; i++) begin
      bus.rd_strobe = 1'b1;
      repeat (4) @(negedge clk);
      bus.rd_strobe = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_strobe_valid", bus.dst_valid, 1'b0);
      check("idle_strobe_busy", bus.busy, 1'b0);
    end

    // Directed channel 1 frame: 21 43 65 87 (then 80 with checksum).
    bus.src = {32'h0BAD_F00D, 32'h8765_4321, 32'h1234_5678};
    run_frame(1, -1, "dir");

    // Second start during byte 2.
    bus.src = {$urandom, $urandom, $urandom};
    run_frame(1, 1, "dup");

    for (int f = 0; f < 10; f++) begin
      bus.src = {$urandom, $urandom, $urandom};
      run_frame($urandom_range(0, 3), -1, $sformatf("rnd%0d", f));
    end

    // Host never strobes after the first byte.
    bus.src = {$urandom, $urandom, $urandom};
    model_frame(bus.src, 0);
    d0 = done_cnt;
    pulse_start(0);
    check("tmo_err_cleared", bus.err, 1'b0);
    wait_valid(1'b1, "tmo_first_valid");
    check("tmo_first_data", bus.dst, exp_q[0]);
    n = 0;
    while (bus.dst_valid === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TIMEOUT);
    check("tmo_busy", bus.busy, 1'b0);
    check("tmo_err", bus.err, 1'b1);
    check("tmo_dst", bus.dst, 8'hFF);
    repeat (3) @(negedge clk);
    check("tmo_no_done", done_cnt - d0, 0);

    run_frame(2, -1, "post_tmo");

    // Out-of-range channel, then reset in the middle of byte 3.
    model_frame(bus.src, 3);
    pulse_start(3);
    for (int i = 0; i < 2; i++) read_byte(exp_q[i], $sformatf("oor_b%0d", i));
    wait_valid(1'b1, "oor_b2_valid");
    check("oor_b2_data", bus.dst, exp_q[2]);
    rst = 1'b1;
    #1;
    check("midrst_valid", bus.dst_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_dst", bus.dst, 8'hFF);
    check("midrst_err", bus.err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("postrst_busy", bus.busy, 1'b0);
    check("postrst_valid", bus.dst_valid, 1'b0);

    bus.src = {$urandom, $urandom, $urandom};
    run_frame(0, -1, "final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
